// File: rtl/seg_pkg.sv
// Shared display-path definitions: BCD digit count, largest four-digit value and
// the converter state encodings.
package seg_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_MAX    = 9999;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } conv_state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_digit (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 step per clock.
// Optional saturation to 9999 with overflow flag: define BIN_TO_BCD_SAT_EN.
module bin_to_bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [15:0]      bcd_o,
    output logic             overflow_o
);

    localparam int          SCR_W     = 4 * BCD_DIGITS;
    localparam logic [3:0]  LAST_STEP = 4'(BIN_W - 1);

    conv_state_t        state;
    logic [BIN_W-1:0]   bin_sr;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_next;
    logic [3:0]         shift_cnt;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .digit    (scratch[4*g +: 4]),
            .adjusted (scratch_adj[4*g +: 4])
        );
    end

    // The bit shifted out of the thousands digit is a 10000s carry; dropping it
    // leaves the value modulo 10000.
    assign scratch_next = SCR_W'({scratch_adj, bin_sr[BIN_W-1]});

`ifdef BIN_TO_BCD_SAT_EN
    logic wrap_seen;
    logic wrap_now;

    // Any carry out of the thousands digit means the input exceeded 9999; it is
    // sticky because later steps of the same conversion need not carry again.
    assign wrap_now = wrap_seen | scratch_adj[SCR_W-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bin_sr     <= '0;
            scratch    <= '0;
            shift_cnt  <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            bcd_o      <= 16'h0000;
            overflow_o <= 1'b0;
`ifdef BIN_TO_BCD_SAT_EN
            wrap_seen  <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        bin_sr    <= bin_i;
                        scratch   <= '0;
                        shift_cnt <= '0;
                        busy_o    <= 1'b1;
                        state     <= SHIFT;
`ifdef BIN_TO_BCD_SAT_EN
                        wrap_seen <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    scratch   <= scratch_next;
                    bin_sr    <= bin_sr << 1;
                    shift_cnt <= shift_cnt + 4'd1;
`ifdef BIN_TO_BCD_SAT_EN
                    wrap_seen <= wrap_now;
`endif
                    if (shift_cnt == LAST_STEP) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
`ifdef BIN_TO_BCD_SAT_EN
                        bcd_o      <= wrap_now ? 16'h9999 : scratch_next;
                        overflow_o <= wrap_now;
`else
                        bcd_o      <= scratch_next;
                        overflow_o <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W = 14); expectations
// follow BIN_TO_BCD_SAT_EN when the bench is built with it.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [13:0] bin_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] bcd_o;
    logic        overflow_o;

    int checks = 0;
    int passes = 0;

`ifdef BIN_TO_BCD_SAT_EN
    localparam logic [15:0] EXP_10000 = 16'h9999;
    localparam logic        OVF_10000 = 1'b1;
    localparam logic [15:0] EXP_16383 = 16'h9999;
    localparam logic        OVF_16383 = 1'b1;
`else
    localparam logic [15:0] EXP_10000 = 16'h0000;
    localparam logic        OVF_10000 = 1'b0;
    localparam logic [15:0] EXP_16383 = 16'h6383;
    localparam logic        OVF_16383 = 1'b0;
`endif

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .bin_i      (bin_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .bcd_o      (bcd_o),
        .overflow_o (overflow_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    // Presents a start for one edge, then scrambles bin_i to prove it is ignored.
    task automatic applyStimulus(input logic [13:0] val);
        start_i = 1'b1;
        bin_i   = val;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        bin_i   = ~val;
    endtask

    task automatic waitDone(input int startLat, output int lat, output int busyCnt);
        lat     = startLat;
        busyCnt = busy_o ? 1 : 0;
        while (!done_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done_o && busy_o) busyCnt++;
        end
    endtask

    task automatic runConversion(input string tag, input logic [13:0] val,
                                 input logic [15:0] expBcd, input logic expOvf);
        int lat;
        int busyCnt;
        applyStimulus(val);
        waitDone(0, lat, busyCnt);
        checkOutput({tag, " latency"}, lat, 14);
        checkOutput({tag, " busy_cycles"}, busyCnt, 14);
        checkOutput({tag, " bcd"}, {16'h0, bcd_o}, {16'h0, expBcd});
        checkOutput({tag, " overflow"}, {31'h0, overflow_o}, {31'h0, expOvf});
    endtask

    task automatic checkPulseEnd(input string tag, input logic [15:0] expBcd);
        @(posedge clk);
        #1;
        checkOutput({tag, " done_one_cycle"}, {31'h0, done_o}, 32'h0);
        checkOutput({tag, " bcd_held"}, {16'h0, bcd_o}, {16'h0, expBcd});
    endtask

    initial begin
        int lat;
        int busyCnt;
        int doneCnt;

        rst_n   = 1'b0;
        start_i = 1'b0;
        bin_i   = '0;
        #12;
        checkOutput("reset busy", {31'h0, busy_o}, 32'h0);
        checkOutput("reset done", {31'h0, done_o}, 32'h0);
        checkOutput("reset bcd", {16'h0, bcd_o}, 32'h0);
        checkOutput("reset overflow", {31'h0, overflow_o}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        runConversion("zero", 14'd0, 16'h0000, 1'b0);
        checkPulseEnd("zero", 16'h0000);
        runConversion("1234", 14'd1234, 16'h1234, 1'b0);
        checkPulseEnd("1234", 16'h1234);
        runConversion("10", 14'd10, 16'h0010, 1'b0);
        runConversion("8765", 14'd8765, 16'h8765, 1'b0);

        runConversion("b2b_9999", 14'd9999, 16'h9999, 1'b0);
        runConversion("b2b_10000", 14'd10000, EXP_10000, OVF_10000);
        checkPulseEnd("b2b_10000", EXP_10000);

        runConversion("16383", 14'd16383, EXP_16383, OVF_16383);

        $display("[TB] start while busy");
        applyStimulus(14'd42);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        start_i = 1'b1;
        bin_i   = 14'd77;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        waitDone(5, lat, busyCnt);
        checkOutput("ignored_start latency", lat, 14);
        checkOutput("ignored_start bcd", {16'h0, bcd_o}, 32'h0042);
        doneCnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_o) doneCnt++;
        end
        checkOutput("ignored_start extra_done", doneCnt, 0);

        $display("[TB] reset during conversion");
        applyStimulus(14'd500);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", {31'h0, busy_o}, 32'h0);
        checkOutput("midreset done", {31'h0, done_o}, 32'h0);
        checkOutput("midreset bcd", {16'h0, bcd_o}, 32'h0);
        checkOutput("midreset overflow", {31'h0, overflow_o}, 32'h0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        doneCnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done_o) doneCnt++;
        end
        checkOutput("midreset no_done", doneCnt, 0);
        checkOutput("midreset busy_after", {31'h0, busy_o}, 32'h0);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        runConversion("after_reset", 14'd500, 16'h0500, 1'b0);
        checkPulseEnd("after_reset", 16'h0500);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
